trace_draw_arbiter: RTL and testbench

- Shares the single pixel-draw datapath between NUM_CH oscilloscope trace channels.
- Each channel presents one (x, y) sample point with a request. The block selects a channel by round-robin and rejects off-screen points.
- Winning samples are tagged with a fixed per-channel colour and issued over a valid/ready handshake to the pixel-draw unit.
- Sits between the per-channel sample/scaling logic and the VGA pixel-draw/framebuffer write port.

---
 rtl/scope_pkg.sv | 32 +++
 rtl/trace_draw_arbiter_rr_select.sv | 33 +++
 rtl/trace_draw_arbiter.sv | 124 ++++++++++++
 tb/tb_trace_draw_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared constants for the oscilloscope trace path: screen limits,
// arbiter state encoding and the fixed per-channel trace colours.
package scope_pkg;

  localparam int X_MAX_DEF = 639;
  localparam int Y_MAX_DEF = 479;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Channels without a table entry are drawn white.
  function automatic rgb_t ch_colour(input logic [3:0] ch);
    rgb_t c;
    case (ch)
      4'd0:    c = '{r: 8'd255, g: 8'd255, b: 8'd0};
      4'd1:    c = '{r: 8'd0,   g: 8'd255, b: 8'd255};
      4'd2:    c = '{r: 8'd255, g: 8'd0,   b: 8'd255};
      4'd3:    c = '{r: 8'd0,   g: 8'd255, b: 8'd0};
      default: c = '{r: 8'd255, g: 8'd255, b: 8'd255};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trace_draw_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first requesting channel
// at or after i_ptr, wrapping modulo NUM_CH.
module rr_select #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_idx
);

  int   w_dist;
  int   w_best;
  logic w_take;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_best  = NUM_CH;
    w_dist  = 0;
    w_take  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dist  = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i - int'(i_ptr) + NUM_CH);
      w_take  = i_req[i] && (w_dist < w_best);
      o_valid = o_valid | w_take;
      o_idx   = w_take ? IDX_W'(i) : o_idx;
      w_best  = w_take ? w_dist : w_best;
    end
  end

endmodule

// File: rtl/trace_draw_arbiter.sv
// Shares one pixel-draw port between NUM_CH trace channels: round-robin
// grant, off-screen clipping with a drop counter, valid/ready issue.
module trace_draw_arbiter
  import scope_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH*X_WIDTH-1:0]   ch_x,
  input  logic [NUM_CH*Y_WIDTH-1:0]   ch_y,
  output logic [NUM_CH-1:0]           ch_ack,
  input  logic                        draw_enable,
  output logic                        draw_valid,
  input  logic                        draw_ready,
  output logic [X_WIDTH-1:0]          draw_x,
  output logic [Y_WIDTH-1:0]          draw_y,
  output logic [7:0]                  draw_R,
  output logic [7:0]                  draw_G,
  output logic [7:0]                  draw_B,
  output logic                        busy,
  output logic [7:0]                  drop_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [NUM_CH-1:0]   r_ack;
  logic                r_valid;
  logic [X_WIDTH-1:0]  r_x;
  logic [Y_WIDTH-1:0]  r_y;
  rgb_t                r_col;
  logic [7:0]          r_drop;

  logic [X_WIDTH-1:0]  w_xs [NUM_CH];
  logic [Y_WIDTH-1:0]  w_ys [NUM_CH];
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_idx;
  logic                w_hs;
  logic                w_grant;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [X_WIDTH-1:0]  w_win_x;
  logic [Y_WIDTH-1:0]  w_win_y;
  rgb_t                w_col;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_xs[g] = ch_x[g*X_WIDTH +: X_WIDTH];
    assign w_ys[g] = ch_y[g*Y_WIDTH +: Y_WIDTH];
  end

  rr_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .i_req   (ch_req),
    .i_ptr   (r_ptr),
    .o_valid (w_sel_valid),
    .o_idx   (w_idx)
  );

  // A grant may only happen when idle or as the current command is taken.
  assign w_hs       = r_valid & draw_ready;
  assign w_grant    = ((r_state == ST_IDLE) | w_hs) & draw_enable & w_sel_valid;
  assign w_win_x    = w_xs[w_idx];
  assign w_win_y    = w_ys[w_idx];
  assign w_in_range = (w_win_x <= X_WIDTH'(X_MAX)) & (w_win_y <= Y_WIDTH'(Y_MAX));
  assign w_next_ptr = (int'(w_idx) == NUM_CH - 1) ? '0 : (w_idx + IDX_W'(1));
  assign w_col      = ch_colour(4'(w_idx));

  // Arbiter FSM with registered command, ack and drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_drop  <= 8'd0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_ptr <= w_next_ptr;
        r_ack <= NUM_CH'(1) << w_idx;
        if (w_in_range) begin
          r_x     <= w_win_x;
          r_y     <= w_win_y;
          r_col   <= w_col;
          r_valid <= 1'b1;
          r_state <= ST_ISSUE;
        end else begin
          r_drop  <= (r_drop == 8'd255) ? r_drop : (r_drop + 8'd1);
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        r_valid <= r_valid;
        r_state <= r_state;
      end
    end
  end

  assign ch_ack     = r_ack;
  assign draw_valid = r_valid;
  assign draw_x     = r_x;
  assign draw_y     = r_y;
  assign draw_R     = r_col.r;
  assign draw_G     = r_col.g;
  assign draw_B     = r_col.b;
  assign busy       = (r_state == ST_ISSUE);
  assign drop_count = r_drop;

endmodule

// File: tb/tb_trace_draw_arbiter.sv
// Directed bench for trace_draw_arbiter: hand-computed expectations checked
// with immediate assertions one time unit after each rising edge.
module tb_trace_draw_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  ch_req;
  logic [39:0] ch_x;
  logic [35:0] ch_y;
  logic [3:0]  ch_ack;
  logic        draw_enable;
  logic        draw_valid;
  logic        draw_ready;
  logic [9:0]  draw_x;
  logic [8:0]  draw_y;
  logic [7:0]  draw_R;
  logic [7:0]  draw_G;
  logic [7:0]  draw_B;
  logic        busy;
  logic [7:0]  drop_count;

  int checks;
  int failures;

  trace_draw_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ch_req      (ch_req),
    .ch_x        (ch_x),
    .ch_y        (ch_y),
    .ch_ack      (ch_ack),
    .draw_enable (draw_enable),
    .draw_valid  (draw_valid),
    .draw_ready  (draw_ready),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_R      (draw_R),
    .draw_G      (draw_G),
    .draw_B      (draw_B),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [23:0] exp_col(input int c);
    case (c)
      0:       return 24'hFFFF00;
      1:       return 24'h00FFFF;
      2:       return 24'hFF00FF;
      3:       return 24'h00FF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input int x, input int y);
    ch_x[c*10 +: 10] = 10'(x);
    ch_y[c*9 +: 9]   = 9'(y);
  endtask

  task automatic chk_cmd(input string tag, input int ack, input int x, input int y, input int c);
    chk({tag, "_ack"},   32'(ch_ack), 32'(ack));
    chk({tag, "_valid"}, 32'(draw_valid), 32'd1);
    chk({tag, "_x"},     32'(draw_x), 32'(x));
    chk({tag, "_y"},     32'(draw_y), 32'(y));
    chk({tag, "_col"},   32'({draw_R, draw_G, draw_B}), 32'(exp_col(c)));
  endtask

  int xs[4] = '{10, 30, 50, 70};
  int ys[4] = '{20, 40, 60, 80};

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    ch_req      = 4'b0000;
    ch_x        = '0;
    ch_y        = '0;
    draw_enable = 1'b1;
    draw_ready  = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(draw_valid), 32'd0);
    chk("rst_ack",   32'(ch_ack), 32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;

    // All channels request: service order 0,1,2,3,0 back-to-back.
    for (int c = 0; c < 4; c++) set_ch(c, xs[c], ys[c]);
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_cmd($sformatf("rr%0d", k), 1 << (k % 4), xs[k % 4], ys[k % 4], k % 4);
    end
    ch_req = 4'b0000;
    tick();
    chk("rr_end_valid", 32'(draw_valid), 32'd0);

    // Reset while a command is stalled, then ch0 must win first.
    draw_ready = 1'b0;
    set_ch(0, 100, 100);
    ch_req = 4'b0001;
    tick();
    chk_cmd("stall", 4'b0001, 100, 100, 0);
    ch_req = 4'b0000;
    tick();
    chk("stall_hold", 32'(draw_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(draw_valid), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    #2;
    reset_n = 1'b1;
    draw_ready = 1'b1;
    set_ch(0, xs[0], ys[0]);
    ch_req = 4'b1111;
    tick();
    chk_cmd("post_rst", 4'b0001, xs[0], ys[0], 0);
    ch_req = 4'b0000;
    tick();
    chk("post_rst_idle", 32'(draw_valid), 32'd0);

    // Off-screen sample on ch2 is dropped; counter saturates at 255.
    set_ch(2, 700, 10);
    ch_req = 4'b0100;
    tick();
    chk("drop1_ack",   32'(ch_ack), 32'b0100);
    chk("drop1_valid", 32'(draw_valid), 32'd0);
    chk("drop1_cnt",   32'(drop_count), 32'd1);
    for (int k = 0; k < 253; k++) tick();
    chk("drop254", 32'(drop_count), 32'd254);
    tick();
    chk("drop255", 32'(drop_count), 32'd255);
    for (int k = 0; k < 46; k++) tick();
    chk("drop_sat",       32'(drop_count), 32'd255);
    chk("drop_sat_valid", 32'(draw_valid), 32'd0);
    ch_req = 4'b0000;
    tick();

    // Corner pixel held for five cycles of draw_ready low.
    draw_ready = 1'b0;
    set_ch(0, 639, 479);
    ch_req = 4'b0001;
    tick();
    chk_cmd("corner", 4'b0001, 639, 479, 0);
    ch_req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_cmd($sformatf("corner_hold%0d", k), 0, 639, 479, 0);
    end
    draw_ready = 1'b1;
    tick();
    chk("corner_done", 32'(draw_valid), 32'd0);

    // draw_enable gates new grants.
    draw_enable = 1'b0;
    set_ch(1, 200, 150);
    ch_req = 4'b0010;
    tick();
    tick();
    chk("gate_ack",   32'(ch_ack), 32'd0);
    chk("gate_valid", 32'(draw_valid), 32'd0);
    draw_enable = 1'b1;
    tick();
    chk_cmd("ungate", 4'b0010, 200, 150, 1);
    ch_req = 4'b0000;
    tick();
    chk("ungate_done", 32'(draw_valid), 32'd0);

    // Park rr_ptr at 3 via a ch2 command, then ch3 in range / ch0 off-screen.
    draw_ready = 1'b0;
    set_ch(2, 5, 5);
    ch_req = 4'b0100;
    tick();
    chk_cmd("park", 4'b0100, 5, 5, 2);
    set_ch(3, 400, 300);
    set_ch(0, 800, 100);
    ch_req = 4'b1001;
    tick();
    chk_cmd("park_hold", 0, 5, 5, 2);
    draw_ready = 1'b1;
    tick();
    chk_cmd("b2b_ch3", 4'b1000, 400, 300, 3);
    ch_req = 4'b0001;
    tick();
    chk("b2b_drop_ack",   32'(ch_ack), 32'b0001);
    chk("b2b_drop_valid", 32'(draw_valid), 32'd0);
    chk("b2b_drop_busy",  32'(busy), 32'd0);
    chk("b2b_drop_cnt",   32'(drop_count), 32'd255);
    ch_req = 4'b0000;
    tick();
    chk("final_ack",   32'(ch_ack), 32'd0);
    chk("final_valid", 32'(draw_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
